// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter in front of a single-port SRAM.
// Optional ARB_ROUND_ROBIN_EN swaps fixed LSU-over-IFU priority for a last-grant pointer.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [7:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_receive_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid
);

    localparam int unsigned   CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic                gnt_lsu_q, gnt_lsu_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                ifu_rv_q, ifu_rv_d;
    logic                lsu_rv_q, lsu_rv_d;
    logic                mem_ren_q, mem_ren_d;
    logic                mem_wen_q, mem_wen_d;
    logic [7:0]          mem_wmask_q, mem_wmask_d;
    logic                pick_lsu_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_lsu_q, last_lsu_d;
    // On a tie the master not granted last time wins.
    assign pick_lsu_c = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
`else
    assign pick_lsu_c = lsu_req_valid;
`endif

    // Request acceptance is combinational and only possible in S_IDLE out of reset.
    assign lsu_req_ready = rst && (state_q == S_IDLE) && pick_lsu_c;
    assign ifu_req_ready = rst && (state_q == S_IDLE) && ifu_req_valid && !pick_lsu_c;

    assign ifu_resp_valid = ifu_rv_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
    assign ifu_resp_err   = err_q;
    assign lsu_resp_err   = err_q;
    assign mem_ren        = mem_ren_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wmask      = mem_wmask_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d           = state_q;
        gnt_lsu_d         = gnt_lsu_q;
        wen_d             = wen_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        cnt_d             = cnt_q;
        rdata_d           = rdata_q;
        err_d             = err_q;
        ifu_rv_d          = ifu_rv_q;
        lsu_rv_d          = lsu_rv_q;
        mem_ren_d         = 1'b0;
        mem_wen_d         = 1'b0;
        mem_wmask_d       = 8'h00;
        mem_receive_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu_d        = last_lsu_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (lsu_req_ready) begin
                    gnt_lsu_d   = 1'b1;
                    wen_d       = lsu_wen;
                    addr_d      = lsu_addr;
                    wdata_d     = lsu_wdata;
                    mem_ren_d   = !lsu_wen;
                    mem_wen_d   = lsu_wen;
                    mem_wmask_d = lsu_wen ? lsu_wmask : 8'h00;
                    state_d     = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_lsu_d  = 1'b1;
`endif
                end else if (ifu_req_ready) begin
                    gnt_lsu_d   = 1'b0;
                    wen_d       = 1'b0;
                    addr_d      = ifu_addr;
                    wdata_d     = '0;
                    mem_ren_d   = 1'b1;
                    state_d     = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_lsu_d  = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                if (wen_q) begin
                    // Writes complete in the issue cycle.
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    ifu_rv_d = !gnt_lsu_q;
                    lsu_rv_d = gnt_lsu_q;
                    state_d  = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_valid) begin
                    rdata_d           = mem_data;
                    err_d             = 1'b0;
                    mem_receive_valid = 1'b1;
                    ifu_rv_d          = !gnt_lsu_q;
                    lsu_rv_d          = gnt_lsu_q;
                    state_d           = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    ifu_rv_d = !gnt_lsu_q;
                    lsu_rv_d = gnt_lsu_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (gnt_lsu_q ? lsu_resp_ready : ifu_resp_ready) begin
                    ifu_rv_d = 1'b0;
                    lsu_rv_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gnt_lsu_q   <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wmask_q <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_lsu_q   <= gnt_lsu_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_wmask_q <= mem_wmask_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q  <= last_lsu_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// timeout, backpressure and async-reset sequences.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO     = 16;
    localparam logic [31:0] IA     = 32'h8000_0000;
    localparam logic [31:0] LA     = 32'h8000_0100;

    logic              clk;
    logic              rst;
    logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]        lsu_wmask;
    logic              mem_ren, mem_wen, mem_receive_valid, mem_valid;
    logic [7:0]        mem_wmask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_data;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_receive_valid(mem_receive_valid),
        .mem_data(mem_data), .mem_valid(mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv, lv, lw, mv;
        logic [31:0] md;
        logic        irr, lrr;
        logic        e_ir, e_lr, e_ren, e_wen, e_rcv, e_irv, e_lrv;
        logic [31:0] e_rdata, e_addr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, lv, lw, mv, input logic [31:0] md, input logic irr, lrr,
                       input logic e_ir, e_lr, e_ren, e_wen, e_rcv, e_irv, e_lrv,
                       input logic [31:0] e_rdata, e_addr);
        vec_t v;
        v.iv = iv; v.lv = lv; v.lw = lw; v.mv = mv; v.md = md; v.irr = irr; v.lrr = lrr;
        v.e_ir = e_ir; v.e_lr = e_lr; v.e_ren = e_ren; v.e_wen = e_wen; v.e_rcv = e_rcv;
        v.e_irv = e_irv; v.e_lrv = e_lrv; v.e_rdata = e_rdata; v.e_addr = e_addr;
        vq.push_back(v);
    endtask

    task automatic ifu_read(input logic [31:0] addr, input logic [31:0] data, input int bp);
        @(negedge clk); ifu_req_valid = 1'b1; ifu_addr = addr;
        #1 chk1("rd accept", ifu_req_ready, 1'b1);
        @(negedge clk); ifu_req_valid = 1'b0;
        #1 chk1("rd ren", mem_ren, 1'b1); chk32("rd addr", mem_addr, addr);
        @(negedge clk); mem_valid = 1'b1; mem_data = data;
        #1 chk1("rd rcv", mem_receive_valid, 1'b1);
        @(negedge clk); mem_valid = 1'b0; lsu_req_valid = (bp > 0); lsu_wen = 1'b1;
        for (int b = 0; b < bp; b++) begin
            #1 chk1("bp resp_valid", ifu_resp_valid, 1'b1);
            chk32("bp rdata", ifu_rdata, data);
            chk1("bp lsu_req_ready", lsu_req_ready, 1'b0);
            @(negedge clk);
        end
        ifu_resp_ready = 1'b1; lsu_req_valid = 1'b0;
        #1 chk1("rd resp_valid", ifu_resp_valid, 1'b1);
        chk32("rd rdata", ifu_rdata, data); chk1("rd err", ifu_resp_err, 1'b0);
        @(negedge clk); ifu_resp_ready = 1'b0;
        #1 chk1("rd resp_valid drop", ifu_resp_valid, 1'b0);
    endtask

    task automatic lsu_read_timeout(input logic late);
        logic exp_rcv;
        @(negedge clk); lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = LA;
        #1 chk1("to accept", lsu_req_ready, 1'b1);
        @(negedge clk); lsu_req_valid = 1'b0;
        #1 chk1("to ren", mem_ren, 1'b1);
        for (int k = 0; k < int'(TO); k++) begin
            exp_rcv = (k == int'(TO) - 1) && late;
            @(negedge clk); mem_valid = exp_rcv; mem_data = 32'h5A5A_0001;
            #1 chk1("to wait resp_valid", lsu_resp_valid, 1'b0);
            chk1("to wait rcv", mem_receive_valid, exp_rcv);
        end
        @(negedge clk); mem_valid = 1'b0; lsu_resp_ready = 1'b1;
        #1 chk1("to resp_valid", lsu_resp_valid, 1'b1);
        chk1("to err", lsu_resp_err, !late);
        chk32("to rdata", lsu_rdata, late ? 32'h5A5A_0001 : 32'h0);
        @(negedge clk); lsu_resp_ready = 1'b0;
        #1 chk1("to resp_valid drop", lsu_resp_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 0; ifu_resp_ready = 0; ifu_addr = IA;
        lsu_req_valid = 0; lsu_resp_ready = 0; lsu_wen = 0; lsu_addr = LA;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        mem_valid = 0; mem_data = 0;

        // iv lv lw mv md | irr lrr | ir lr ren wen rcv irv lrv | rdata addr
        add(0,0,0,0,0,            0,0, 0,0,0,0,0,0,0, 0,0);
        add(1,0,0,0,0,            0,0, 1,0,0,0,0,0,0, 0,0);
        add(0,0,0,0,0,            0,0, 0,0,1,0,0,0,0, 0,IA);
        add(0,0,0,1,32'h413,      0,0, 0,0,0,0,1,0,0, 0,0);
        add(0,0,0,0,0,            1,0, 0,0,0,0,0,1,0, 32'h413,0);
        add(0,0,0,1,32'hFFFF,     0,0, 0,0,0,0,0,0,0, 0,0);
        add(0,1,1,0,0,            0,0, 0,1,0,0,0,0,0, 0,0);
        add(0,0,0,1,0,            0,0, 0,0,0,1,0,0,0, 0,LA);
        add(0,0,0,0,0,            0,1, 0,0,0,0,0,0,1, 0,0);
        add(0,0,0,0,0,            0,0, 0,0,0,0,0,0,0, 0,0);
`ifdef ARB_ROUND_ROBIN_EN
        add(1,1,0,0,0,            0,0, 1,0,0,0,0,0,0, 0,0);
        add(0,1,0,0,0,            0,0, 0,0,1,0,0,0,0, 0,IA);
        add(0,1,0,1,32'h1234_5678,0,0, 0,0,0,0,1,0,0, 0,0);
        add(0,1,0,0,0,            1,0, 0,0,0,0,0,1,0, 32'h1234_5678,0);
        add(1,1,0,0,0,            0,0, 0,1,0,0,0,0,0, 0,0);
        add(0,0,0,0,0,            0,0, 0,0,1,0,0,0,0, 0,LA);
        add(0,0,0,1,32'hCAFE_F00D,0,0, 0,0,0,0,1,0,0, 0,0);
        add(0,0,0,0,0,            0,1, 0,0,0,0,0,0,1, 32'hCAFE_F00D,0);
`else
        add(1,1,0,0,0,            0,0, 0,1,0,0,0,0,0, 0,0);
        add(1,0,0,0,0,            0,0, 0,0,1,0,0,0,0, 0,LA);
        add(1,0,0,1,32'h1234_5678,0,0, 0,0,0,0,1,0,0, 0,0);
        add(1,0,0,0,0,            0,1, 0,0,0,0,0,0,1, 32'h1234_5678,0);
        add(1,0,0,0,0,            0,0, 1,0,0,0,0,0,0, 0,0);
        add(0,0,0,0,0,            0,0, 0,0,1,0,0,0,0, 0,IA);
        add(0,0,0,1,32'hCAFE_F00D,0,0, 0,0,0,0,1,0,0, 0,0);
        add(0,0,0,0,0,            1,0, 0,0,0,0,0,1,0, 32'hCAFE_F00D,0);
`endif
        add(0,0,0,0,0,            0,0, 0,0,0,0,0,0,0, 0,0);

        repeat (2) @(negedge clk);
        #1 chk1("reset mem_ren", mem_ren, 1'b0);
        chk1("reset ifu_resp_valid", ifu_resp_valid, 1'b0);
        @(negedge clk); rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            ifu_req_valid = vq[i].iv; lsu_req_valid = vq[i].lv; lsu_wen = vq[i].lw;
            mem_valid = vq[i].mv; mem_data = vq[i].md;
            ifu_resp_ready = vq[i].irr; lsu_resp_ready = vq[i].lrr;
            #1;
            chk1($sformatf("row%0d ifu_req_ready", i), ifu_req_ready, vq[i].e_ir);
            chk1($sformatf("row%0d lsu_req_ready", i), lsu_req_ready, vq[i].e_lr);
            chk1($sformatf("row%0d mem_ren", i), mem_ren, vq[i].e_ren);
            chk1($sformatf("row%0d mem_wen", i), mem_wen, vq[i].e_wen);
            chk1($sformatf("row%0d mem_receive_valid", i), mem_receive_valid, vq[i].e_rcv);
            chk1($sformatf("row%0d ifu_resp_valid", i), ifu_resp_valid, vq[i].e_irv);
            chk1($sformatf("row%0d lsu_resp_valid", i), lsu_resp_valid, vq[i].e_lrv);
            chk32($sformatf("row%0d mem_wmask", i), 32'(mem_wmask), vq[i].e_wen ? 32'h0F : 32'h0);
            if (vq[i].e_ren || vq[i].e_wen)
                chk32($sformatf("row%0d mem_addr", i), mem_addr, vq[i].e_addr);
            if (vq[i].e_wen)
                chk32($sformatf("row%0d mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
            if (vq[i].e_irv) begin
                chk32($sformatf("row%0d ifu_rdata", i), ifu_rdata, vq[i].e_rdata);
                chk1($sformatf("row%0d ifu_resp_err", i), ifu_resp_err, 1'b0);
            end
            if (vq[i].e_lrv) begin
                chk32($sformatf("row%0d lsu_rdata", i), lsu_rdata, vq[i].e_rdata);
                chk1($sformatf("row%0d lsu_resp_err", i), lsu_resp_err, 1'b0);
            end
        end
        ifu_req_valid = 0; lsu_req_valid = 0; mem_valid = 0;
        ifu_resp_ready = 0; lsu_resp_ready = 0;

        lsu_read_timeout(1'b0);
        ifu_read(IA + 32'h10, 32'h0000_0093, 0);
        lsu_read_timeout(1'b1);

        ifu_read(IA + 32'h20, 32'h0010_0073, 5);

        // Async reset while waiting on the SRAM.
        @(negedge clk); ifu_req_valid = 1'b1; ifu_addr = IA;
        @(negedge clk); ifu_req_valid = 1'b0;
        @(negedge clk);
        #1 chk32("pre-reset mem_addr", mem_addr, IA);
        #1 rst = 1'b0;
        #1 chk1("arst mem_ren", mem_ren, 1'b0);
        chk1("arst mem_wen", mem_wen, 1'b0);
        chk32("arst mem_addr", mem_addr, 32'h0);
        chk32("arst mem_wdata", mem_wdata, 32'h0);
        chk32("arst mem_wmask", 32'(mem_wmask), 32'h0);
        chk1("arst ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk1("arst lsu_resp_valid", lsu_resp_valid, 1'b0);
        chk32("arst ifu_rdata", ifu_rdata, 32'h0);
        chk1("arst ifu_resp_err", ifu_resp_err, 1'b0);
        chk1("arst ifu_req_ready", ifu_req_ready, 1'b0);
        chk1("arst mem_receive_valid", mem_receive_valid, 1'b0);
        @(negedge clk); mem_valid = 1'b1; mem_data = 32'h1111_2222;
        @(negedge clk); rst = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        #1 chk1("post-reset no response", ifu_resp_valid, 1'b0);
        ifu_read(IA + 32'h4, 32'h0000_0013, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
